// File: rtl/highrisc_pkg.sv
// Shared HighRISC decode types: opcode and decoder state enums, field widths,
// and the opcode classification helpers used by instr_decode.
package highrisc_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 6;
  localparam int OPC_W  = 4;

  localparam logic [OPC_W-1:0] IMM_OP_MIN = 4'hC;

  typedef enum logic [OPC_W-1:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_SHL  = 4'h6,
    OP_SHR  = 4'h7,
    OP_MOV  = 4'h8,
    OP_LD   = 4'h9,
    OP_NOT  = 4'hA,
    OP_SLT  = 4'hB,
    OP_LDI  = 4'hC,
    OP_ADDI = 4'hD,
    OP_BRZ  = 4'hE,
    OP_JMP  = 4'hF
  } opcode_t;

  typedef enum logic [1:0] {
    S_WORD0 = 2'd0,
    S_IMM   = 2'd1,
    S_OUT   = 2'd2
  } state_t;

  // Opcodes from IMM_OP_MIN upward carry a second fetch word as their immediate.
  function automatic logic isImmClass(input opcode_t op);
    return logic'(op >= IMM_OP_MIN);
  endfunction

  // Everything except NOP and the two control-flow ops writes AddressA.
  function automatic logic isWriteClass(input opcode_t op);
    return logic'((op != OP_NOP) && (op != OP_BRZ) && (op != OP_JMP));
  endfunction

endpackage

// File: rtl/instr_decode.sv
// HighRISC fetch-word decoder with valid/ready on both sides and a zero-bubble S_OUT path.
// Optional macro DECODE_STATS_EN adds a saturating InstrCount of output handshakes.
module instr_decode
  import highrisc_pkg::*;
#(
  parameter logic [15:0] ILLEGAL_MASK = 16'h0000
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              InstrValid,
  input  logic [DATA_W-1:0] Instr,
  output logic              InstrReady,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [OPC_W-1:0]  Opcode,
  output logic [ADDR_W-1:0] AddressA,
  output logic [ADDR_W-1:0] AddressB,
  output logic [DATA_W-1:0] Immediate,
  output logic              HasImm,
  output logic              WriteEnable,
  output logic              Illegal
`ifdef DECODE_STATS_EN
  ,
  output logic [15:0]       InstrCount
`endif
);

  state_t  state;
  state_t  nextState;
  opcode_t newOp;
  logic    newIllegal;
  logic    loadWord0;
  logic    loadImm;

  assign newOp      = opcode_t'(Instr[15:12]);
  assign newIllegal = ILLEGAL_MASK[newOp];
  assign OutValid   = (state == S_OUT);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= S_WORD0;
    end else begin
      state <= nextState;
    end
  end

  // In S_OUT a consumed output may be replaced by a fresh first word in the same edge.
  always_comb begin
    nextState  = state;
    loadWord0  = 1'b0;
    loadImm    = 1'b0;
    InstrReady = 1'b1;
    case (state)
      S_WORD0: begin
        if (InstrValid) begin
          loadWord0 = 1'b1;
          nextState = isImmClass(newOp) ? S_IMM : S_OUT;
        end
      end
      S_IMM: begin
        if (InstrValid) begin
          loadImm   = 1'b1;
          nextState = S_OUT;
        end
      end
      S_OUT: begin
        InstrReady = OutReady;
        if (OutReady) begin
          if (InstrValid) begin
            loadWord0 = 1'b1;
            nextState = isImmClass(newOp) ? S_IMM : S_OUT;
          end else begin
            nextState = S_WORD0;
          end
        end
      end
      default: begin
        nextState = S_WORD0;
      end
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      Opcode      <= '0;
      AddressA    <= '0;
      AddressB    <= '0;
      Immediate   <= '0;
      HasImm      <= 1'b0;
      WriteEnable <= 1'b0;
      Illegal     <= 1'b0;
    end else if (loadWord0) begin
      Opcode      <= newOp;
      AddressA    <= Instr[11:6];
      AddressB    <= Instr[5:0];
      Immediate   <= '0;
      HasImm      <= isImmClass(newOp);
      WriteEnable <= isWriteClass(newOp) && !newIllegal;
      Illegal     <= newIllegal;
    end else if (loadImm) begin
      Immediate   <= Instr;
    end
  end

`ifdef DECODE_STATS_EN
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      InstrCount <= '0;
    end else if (OutValid && OutReady && (InstrCount != 16'hFFFF)) begin
      InstrCount <= InstrCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_decode.sv
// Directed self-checking bench for instr_decode, built with bit 8 of ILLEGAL_MASK set.
// Expected values are hand-decoded from the fetch words in each step.
module tb_instr_decode;

  logic        Clock;
  logic        Reset;
  logic        InstrValid;
  logic [15:0] Instr;
  logic        InstrReady;
  logic        OutValid;
  logic        OutReady;
  logic [3:0]  Opcode;
  logic [5:0]  AddressA;
  logic [5:0]  AddressB;
  logic [15:0] Immediate;
  logic        HasImm;
  logic        WriteEnable;
  logic        Illegal;
`ifdef DECODE_STATS_EN
  logic [15:0] InstrCount;
`endif

  int checkCount = 0;
  int errorCount = 0;

  instr_decode #(.ILLEGAL_MASK(16'h0100)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .InstrValid  (InstrValid),
    .Instr       (Instr),
    .InstrReady  (InstrReady),
    .OutValid    (OutValid),
    .OutReady    (OutReady),
    .Opcode      (Opcode),
    .AddressA    (AddressA),
    .AddressB    (AddressB),
    .Immediate   (Immediate),
    .HasImm      (HasImm),
    .WriteEnable (WriteEnable),
    .Illegal     (Illegal)
`ifdef DECODE_STATS_EN
    ,
    .InstrCount  (InstrCount)
`endif
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [15:0] word, input logic ready);
    InstrValid = valid;
    Instr      = word;
    OutReady   = ready;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    Reset = 1'b1;
    applyStimulus(1'b0, 16'h0000, 1'b0);
    #2;
    checkOutput("rst OutValid", OutValid, 0);
    checkOutput("rst Opcode", Opcode, 0);
    checkOutput("rst AddressA", AddressA, 0);
    checkOutput("rst AddressB", AddressB, 0);
    checkOutput("rst Immediate", Immediate, 0);
    checkOutput("rst HasImm", HasImm, 0);
    checkOutput("rst WriteEnable", WriteEnable, 0);
    checkOutput("rst Illegal", Illegal, 0);
    checkOutput("rst InstrReady", InstrReady, 1);
`ifdef DECODE_STATS_EN
    checkOutput("rst InstrCount", InstrCount, 0);
`endif

    // Release reset between edges; first word goes in on the very next edge.
    #10;
    Reset = 1'b0;
    applyStimulus(1'b1, 16'h1083, 1'b1);
    #1;
    checkOutput("word0 InstrReady", InstrReady, 1);
    tick();
    checkOutput("add OutValid", OutValid, 1);
    checkOutput("add Opcode", Opcode, 4'h1);
    checkOutput("add AddressA", AddressA, 2);
    checkOutput("add AddressB", AddressB, 3);
    checkOutput("add WriteEnable", WriteEnable, 1);
    checkOutput("add HasImm", HasImm, 0);
    checkOutput("add Immediate", Immediate, 0);
    checkOutput("add Illegal", Illegal, 0);

    // Back-to-back second word decodes in the same edge the first is consumed.
    applyStimulus(1'b1, 16'h2145, 1'b1);
    #1;
    checkOutput("b2b InstrReady", InstrReady, 1);
    tick();
    checkOutput("sub OutValid", OutValid, 1);
    checkOutput("sub Opcode", Opcode, 4'h2);
    checkOutput("sub AddressA", AddressA, 5);
    checkOutput("sub AddressB", AddressB, 5);

    // Two-word LDI with a stalled immediate fetch.
    applyStimulus(1'b1, 16'hC040, 1'b1);
    tick();
    checkOutput("ldi w0 OutValid", OutValid, 0);
    checkOutput("ldi w0 InstrReady", InstrReady, 1);
    applyStimulus(1'b0, 16'hDEAD, 1'b1);
    for (int i = 0; i < 3; i++) tick();
    checkOutput("imm stall OutValid", OutValid, 0);
    applyStimulus(1'b1, 16'hBEEF, 1'b0);
    #1;
    checkOutput("imm InstrReady", InstrReady, 1);
    tick();
    checkOutput("ldi OutValid", OutValid, 1);
    checkOutput("ldi Opcode", Opcode, 4'hC);
    checkOutput("ldi AddressA", AddressA, 1);
    checkOutput("ldi AddressB", AddressB, 0);
    checkOutput("ldi Immediate", Immediate, 16'hBEEF);
    checkOutput("ldi HasImm", HasImm, 1);
    checkOutput("ldi WriteEnable", WriteEnable, 1);
    checkOutput("ldi InstrReady", InstrReady, 0);

    // Back-pressure: outputs hold and the waiting word is not consumed.
    applyStimulus(1'b1, 16'h2145, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("hold OutValid", OutValid, 1);
      checkOutput("hold Opcode", Opcode, 4'hC);
      checkOutput("hold Immediate", Immediate, 16'hBEEF);
      checkOutput("hold InstrReady", InstrReady, 0);
    end
    applyStimulus(1'b0, 16'h0000, 1'b1);
    #1;
    checkOutput("release InstrReady", InstrReady, 1);
    tick();
    checkOutput("release OutValid", OutValid, 0);
    checkOutput("release Opcode", Opcode, 4'hC);

    // Reset in the middle of a two-word fetch drops the partial instruction.
    applyStimulus(1'b1, 16'hC040, 1'b1);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b1);
    Reset = 1'b1;
    #1;
    checkOutput("midrst OutValid", OutValid, 0);
    checkOutput("midrst Opcode", Opcode, 0);
    checkOutput("midrst AddressA", AddressA, 0);
    checkOutput("midrst HasImm", HasImm, 0);
`ifdef DECODE_STATS_EN
    checkOutput("midrst InstrCount", InstrCount, 0);
`endif
    Reset = 1'b0;
    applyStimulus(1'b1, 16'h0000, 1'b1);
    tick();
    checkOutput("nop OutValid", OutValid, 1);
    checkOutput("nop Opcode", Opcode, 0);
    checkOutput("nop WriteEnable", WriteEnable, 0);
    checkOutput("nop HasImm", HasImm, 0);
    checkOutput("nop Immediate", Immediate, 0);

    // Opcode 8 is masked illegal: still handshakes, never writes.
    applyStimulus(1'b1, 16'h8000, 1'b1);
    tick();
    checkOutput("ill OutValid", OutValid, 1);
    checkOutput("ill Opcode", Opcode, 4'h8);
    checkOutput("ill Illegal", Illegal, 1);
    checkOutput("ill WriteEnable", WriteEnable, 0);
`ifdef DECODE_STATS_EN
    checkOutput("ill InstrCount before", InstrCount, 1);
`endif
    applyStimulus(1'b0, 16'h0000, 1'b1);
    tick();
    checkOutput("ill done OutValid", OutValid, 0);
`ifdef DECODE_STATS_EN
    checkOutput("ill InstrCount after", InstrCount, 2);
`endif

    // JMP is two-word but does not write AddressA.
    applyStimulus(1'b1, 16'hF000, 1'b0);
    tick();
    checkOutput("jmp w0 OutValid", OutValid, 0);
    applyStimulus(1'b1, 16'h1234, 1'b0);
    tick();
    checkOutput("jmp OutValid", OutValid, 1);
    checkOutput("jmp Opcode", Opcode, 4'hF);
    checkOutput("jmp WriteEnable", WriteEnable, 0);
    checkOutput("jmp HasImm", HasImm, 1);
    checkOutput("jmp Immediate", Immediate, 16'h1234);
    checkOutput("jmp Illegal", Illegal, 0);

    // Reset while an output is held: it vanishes with no later handshake.
    applyStimulus(1'b0, 16'h0000, 1'b0);
    Reset = 1'b1;
    #1;
    checkOutput("outrst OutValid", OutValid, 0);
    checkOutput("outrst Immediate", Immediate, 0);
    Reset = 1'b0;
    applyStimulus(1'b0, 16'h0000, 1'b1);
    tick();
    checkOutput("outrst after OutValid", OutValid, 0);
`ifdef DECODE_STATS_EN
    checkOutput("outrst InstrCount", InstrCount, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
